// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between the control unit, the writeback stage, the register file
// and the operand-fetch initiator. The initiator block sits on the slave modport.
interface regfile_access_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int NREG = 1 << AW;

  logic            op_valid;
  logic            op_ready;
  logic [AW-1:0]   op_rs1;
  logic [AW-1:0]   op_rs2;
  logic [AW-1:0]   op_rd;
  logic            op_wr;

  logic            opnd_valid;
  logic            opnd_ready;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;

  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [AW-1:0]   rf_read_reg1;
  logic [AW-1:0]   rf_read_reg2;
  logic [XLEN-1:0] rf_read_data1;
  logic [XLEN-1:0] rf_read_data2;
  logic [AW-1:0]   rf_write_reg;
  logic [XLEN-1:0] rf_write_data;
  logic            rf_reg_write;

  logic [NREG-1:0] busy_mask;

  modport slave (
    input  op_valid, op_rs1, op_rs2, op_rd, op_wr,
    output op_ready,
    output opnd_valid, opnd_a, opnd_b,
    input  opnd_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    output rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data, rf_reg_write,
    input  rf_read_data1, rf_read_data2,
    output busy_mask
  );

  modport master (
    output op_valid, op_rs1, op_rs2, op_rd, op_wr,
    input  op_ready,
    input  opnd_valid, opnd_a, opnd_b,
    output opnd_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    input  rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data, rf_reg_write,
    output rf_read_data1, rf_read_data2,
    input  busy_mask
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch sequencer and writeback driver for the 2R/1W register file,
// with a per-register busy scoreboard that stalls fetches on pending writes.
module regfile_access_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_access_ctrl_if.slave bus
);
  localparam int NREG = 1 << AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0] opnd_a_q, opnd_a_d;
  logic [XLEN-1:0] opnd_b_q, opnd_b_d;
  logic            opnd_valid_q, opnd_valid_d;
  logic            wb_ready_q;

  logic            wb_fire;
  logic            op_fire;
  logic            op_ready;
  logic            hz;
  logic [NREG-1:0] wb_clr_mask;
  logic [NREG-1:0] op_set_mask;
  logic [NREG-1:0] busy_eff;

  assign wb_fire     = bus.wb_valid & wb_ready_q;
  assign wb_clr_mask = wb_fire ? (NREG'(1) << bus.wb_rd) : '0;

  // A writeback completing this cycle releases its register for the hazard check.
  assign busy_eff = busy_q & ~wb_clr_mask & ~NREG'(1);
  assign hz       = busy_eff[bus.op_rs1] | busy_eff[bus.op_rs2]
                  | (bus.op_wr & busy_eff[bus.op_rd]);

  assign op_ready = (state_q == ST_IDLE) && !hz;
  assign op_fire  = bus.op_valid && op_ready;

  assign op_set_mask = (op_fire && bus.op_wr && (bus.op_rd != '0))
                     ? (NREG'(1) << bus.op_rd) : '0;

  // Set after clear so a new reservation wins over a same-cycle writeback.
  assign busy_d = (busy_q & ~wb_clr_mask) | op_set_mask;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    opnd_a_d     = opnd_a_q;
    opnd_b_d     = opnd_b_q;
    opnd_valid_d = opnd_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (op_fire) begin
          rs1_d   = bus.op_rs1;
          rs2_d   = bus.op_rs2;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        opnd_a_d     = bus.rf_read_data1;
        opnd_b_d     = bus.rf_read_data2;
        opnd_valid_d = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.opnd_ready) begin
          opnd_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      opnd_a_q     <= '0;
      opnd_b_q     <= '0;
      opnd_valid_q <= 1'b0;
      wb_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      opnd_a_q     <= opnd_a_d;
      opnd_b_q     <= opnd_b_d;
      opnd_valid_q <= opnd_valid_d;
      wb_ready_q   <= 1'b1;
    end
  end

  assign bus.op_ready      = op_ready;
  assign bus.opnd_valid    = opnd_valid_q;
  assign bus.opnd_a        = opnd_a_q;
  assign bus.opnd_b        = opnd_b_q;
  assign bus.wb_ready      = wb_ready_q;
  assign bus.rf_read_reg1  = rs1_q;
  assign bus.rf_read_reg2  = rs2_q;
  assign bus.rf_write_reg  = bus.wb_rd;
  assign bus.rf_write_data = bus.wb_data;
  // x0 writes complete the handshake but never reach the file.
  assign bus.rf_reg_write  = wb_fire && (bus.wb_rd != '0);
  assign bus.busy_mask     = busy_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: expected operand pairs go into a
// scoreboard queue; a monitor pops them whenever an operand transfer occurs.
module tb_regfile_access_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } opnd_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  opnd_t sb_q[$];
  logic [XLEN-1:0] rf_mem [1<<AW];

  regfile_access_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_access_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational reads, x0 hardwired to zero.
  always @(posedge clk)
    if (bus.rf_reg_write) rf_mem[bus.rf_write_reg] <= bus.rf_write_data;
  assign bus.rf_read_data1 = (bus.rf_read_reg1 == '0) ? '0 : rf_mem[bus.rf_read_reg1];
  assign bus.rf_read_data2 = (bus.rf_read_reg2 == '0) ? '0 : rf_mem[bus.rf_read_reg2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.opnd_valid && bus.opnd_ready) begin
      if (sb_q.size() == 0) begin
        check("opnd_unexpected", 32'd1, 32'd0);
      end else begin
        opnd_t e;
        e = sb_q.pop_front();
        check("opnd_a", bus.opnd_a, e.a);
        check("opnd_b", bus.opnd_b, e.b);
      end
    end
  end

  task automatic drive_wb(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
  endtask

  task automatic drive_op(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic wr);
    bus.op_valid = v;
    bus.op_rs1   = rs1;
    bus.op_rs2   = rs2;
    bus.op_rd    = rd;
    bus.op_wr    = wr;
  endtask

  // Presents a request, waits (bounded) for acceptance and returns 1ns after
  // the accepting edge.
  task automatic issue_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic wr,
                          input logic [XLEN-1:0] exp_a, input logic [XLEN-1:0] exp_b,
                          input bit push);
    int cyc;
    opnd_t e;
    @(posedge clk); #1;
    drive_op(1'b1, rs1, rs2, rd, wr);
    cyc = 0;
    @(negedge clk);
    while (!bus.op_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("op_accept", 32'(bus.op_ready), 32'd1);
    if (push) begin
      e.a = exp_a;
      e.b = exp_b;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    opnd_t e;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive_op(1'b0, '0, '0, '0, 1'b0);
    drive_wb(1'b0, '0, '0);
    bus.opnd_ready = 1'b1;

    // Reset state and registered wb_ready release
    @(negedge clk);
    check("rst_busy", bus.busy_mask, 32'h0);
    check("rst_opnd_valid", 32'(bus.opnd_valid), 32'd0);
    check("rst_opnd_a", bus.opnd_a, 32'h0);
    check("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("wb_ready_before_edge", 32'(bus.wb_ready), 32'd0);
    @(posedge clk); #1;
    check("wb_ready_after_edge", 32'(bus.wb_ready), 32'd1);

    // Preload x3/x4 through the writeback path (non-busy writes)
    drive_wb(1'b1, 5'd3, 32'h11);
    @(negedge clk);
    check("preload_we", 32'(bus.rf_reg_write), 32'd1);
    check("preload_reg", 32'(bus.rf_write_reg), 32'd3);
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd4, 32'h22);
    @(negedge clk);
    check("preload_busy", bus.busy_mask, 32'h0);
    @(posedge clk); #1;
    drive_wb(1'b0, '0, '0);

    // Basic fetch with reservation of x5, latency of one edge
    issue_op(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, 1'b1);
    @(negedge clk);
    check("basic_busy", bus.busy_mask, 32'h20);
    check("basic_read_not_valid", 32'(bus.opnd_valid), 32'd0);
    @(negedge clk);
    check("basic_latency_valid", 32'(bus.opnd_valid), 32'd1);

    // RAW stall on x5, released by a same-cycle writeback
    @(posedge clk); #1;
    drive_op(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("raw_stall", 32'(bus.op_ready), 32'd0);
    end
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd5, 32'hABCD);
    @(negedge clk);
    check("raw_bypass_ready", 32'(bus.op_ready), 32'd1);
    check("raw_wb_we", 32'(bus.rf_reg_write), 32'd1);
    e.a = 32'hABCD;
    e.b = 32'h0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    drive_wb(1'b0, '0, '0);
    @(negedge clk);
    check("raw_busy_cleared", bus.busy_mask, 32'h0);
    @(negedge clk);

    // x0: writeback handshakes without enable, reservation of x0 ignored
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    check("x0_wb_ready", 32'(bus.wb_ready), 32'd1);
    check("x0_wb_we", 32'(bus.rf_reg_write), 32'd0);
    @(posedge clk); #1;
    drive_wb(1'b0, '0, '0);
    issue_op(5'd0, 5'd3, 5'd0, 1'b1, 32'h0, 32'h11, 1'b1);
    @(negedge clk);
    check("x0_busy", bus.busy_mask, 32'h0);
    @(negedge clk);

    // Reserve x7, then WAW stall and set/clear collision
    issue_op(5'd4, 5'd3, 5'd7, 1'b1, 32'h22, 32'h11, 1'b1);
    @(negedge clk);
    check("x7_busy", bus.busy_mask, 32'h80);
    @(negedge clk);
    @(posedge clk); #1;
    drive_op(1'b1, 5'd3, 5'd4, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("waw_stall", 32'(bus.op_ready), 32'd0);
    end
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd7, 32'h77);
    @(negedge clk);
    check("collision_ready", 32'(bus.op_ready), 32'd1);
    e.a = 32'h11;
    e.b = 32'h22;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    drive_wb(1'b0, '0, '0);
    @(negedge clk);
    check("collision_busy", bus.busy_mask, 32'h80);
    @(negedge clk);
    @(posedge clk); #1;
    drive_wb(1'b1, 5'd7, 32'h78);
    @(posedge clk); #1;
    drive_wb(1'b0, '0, '0);
    @(negedge clk);
    check("x7_released", bus.busy_mask, 32'h0);

    // Backpressure: operands held stable while a write to x3 lands
    bus.opnd_ready = 1'b0;
    issue_op(5'd7, 5'd3, 5'd0, 1'b0, 32'h78, 32'h11, 1'b1);
    drive_wb(1'b1, 5'd3, 32'h99);
    @(negedge clk);
    @(posedge clk); #1;
    drive_wb(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.opnd_valid), 32'd1);
      check("bp_op_ready", 32'(bus.op_ready), 32'd0);
      check("bp_a_stable", bus.opnd_a, 32'h78);
      check("bp_b_stable", bus.opnd_b, 32'h11);
    end
    @(posedge clk); #1;
    bus.opnd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(bus.opnd_valid), 32'd0);
    check("bp_release_idle", 32'(bus.op_ready), 32'd1);

    // Reset asserted mid-HOLD with x4 reserved; this fetch is dropped
    bus.opnd_ready = 1'b0;
    issue_op(5'd3, 5'd4, 5'd4, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", bus.busy_mask, 32'h10);
    check("pre_rst_valid", 32'(bus.opnd_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_wb(1'b1, 5'd6, 32'h66);
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.opnd_valid), 32'd0);
    check("mid_rst_busy", bus.busy_mask, 32'h0);
    check("mid_rst_opnd_a", bus.opnd_a, 32'h0);
    check("mid_rst_wb_ready", 32'(bus.wb_ready), 32'd0);
    check("mid_rst_we", 32'(bus.rf_reg_write), 32'd0);
    check("mid_rst_idle", 32'(bus.op_ready), 32'd1);
    check("mid_rst_rs1", 32'(bus.rf_read_reg1), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_wb_ready_before", 32'(bus.wb_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_wb_ready_after", 32'(bus.wb_ready), 32'd1);
    drive_wb(1'b0, '0, '0);
    bus.opnd_ready = 1'b1;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
